// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers plus a two-state data-memory
// access FSM that stalls the front end while a load/store waits for dmem_ready.
// Revision: 1.0
`default_nettype none

module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_write_reg_addr,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        ex_mem_reg_write,
  output logic [4:0]  ex_mem_write_reg_addr,
  output logic [31:0] ex_mem_alu_result,
  output logic        mem_wb_reg_write,
  output logic [4:0]  mem_wb_write_reg_addr,
  output logic [31:0] mem_wb_write_data,
  output logic        stall,
  output logic        align_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_exm_valid;
  logic        r_exm_reg_write;
  logic        r_exm_mem_read;
  logic        r_exm_mem_write;
  logic        r_exm_mem_to_reg;
  logic [4:0]  r_exm_addr;
  logic [31:0] r_exm_alu;
  logic [31:0] r_exm_store;

  logic        r_mwb_reg_write;
  logic [4:0]  r_mwb_addr;
  logic [31:0] r_mwb_data;

  logic        r_flush_pending;
  logic        r_align_err;

  logic        w_stall;
  logic        w_advance;
  logic        w_ex_live;
  logic        w_ex_memop;
  logic        w_ex_misal;
  logic        w_ex_enter_mem;

  assign w_advance      = !w_stall;
  assign w_ex_live      = ex_valid && !flush && !r_flush_pending;
  assign w_ex_memop     = ex_mem_read || ex_mem_write;
  assign w_ex_misal     = w_ex_memop && (ex_alu_result[1:0] != 2'b00);
  assign w_ex_enter_mem = w_ex_live && w_ex_memop && !w_ex_misal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In WAIT the next state is only evaluated once the access completes.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    dmem_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ex_enter_mem) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        w_stall  = !dmem_ready;
        if (dmem_ready) w_state_nxt = w_ex_enter_mem ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exm_valid      <= 1'b0;
      r_exm_reg_write  <= 1'b0;
      r_exm_mem_read   <= 1'b0;
      r_exm_mem_write  <= 1'b0;
      r_exm_mem_to_reg <= 1'b0;
      r_exm_addr       <= 5'd0;
      r_exm_alu        <= 32'd0;
      r_exm_store      <= 32'd0;
    end else if (w_advance) begin
      // A misaligned access becomes a bubble here rather than entering WAIT.
      r_exm_valid      <= w_ex_live && !w_ex_misal;
      r_exm_reg_write  <= ex_reg_write;
      r_exm_mem_read   <= ex_mem_read;
      r_exm_mem_write  <= ex_mem_write;
      r_exm_mem_to_reg <= ex_mem_to_reg;
      r_exm_addr       <= ex_write_reg_addr;
      r_exm_alu        <= ex_alu_result;
      r_exm_store      <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mwb_reg_write <= 1'b0;
      r_mwb_addr      <= 5'd0;
      r_mwb_data      <= 32'd0;
    end else if (w_advance) begin
      r_mwb_reg_write <= r_exm_valid && r_exm_reg_write && !r_exm_mem_write &&
                         (r_exm_addr != 5'd0);
      r_mwb_addr      <= r_exm_addr;
      r_mwb_data      <= (r_exm_mem_read && r_exm_mem_to_reg) ? dmem_rdata : r_exm_alu;
    end else begin
      r_mwb_reg_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pending <= 1'b0;
      r_align_err     <= 1'b0;
    end else begin
      r_flush_pending <= w_stall && (r_flush_pending || flush);
      r_align_err     <= w_advance && w_ex_live && w_ex_misal;
    end
  end

  assign stall                 = w_stall;
  assign dmem_we               = dmem_req && r_exm_mem_write;
  assign dmem_addr             = r_exm_alu;
  assign dmem_wdata            = r_exm_store;
  assign ex_mem_reg_write      = r_exm_valid && r_exm_reg_write;
  assign ex_mem_write_reg_addr = r_exm_addr;
  assign ex_mem_alu_result     = r_exm_alu;
  assign mem_wb_reg_write      = r_mwb_reg_write;
  assign mem_wb_write_reg_addr = r_mwb_addr;
  assign mem_wb_write_data     = r_mwb_data;
  assign align_err             = r_align_err;

endmodule

`default_nettype wire
